// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - AES SubBytes engine: substitutes LANES bytes of a captured word per cycle,
// forward or inverse S-box selected per word, with valid/ready handshakes on both sides.
module sub_bytes_engine #(
  parameter int NBYTES = 4,
  parameter int LANES  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  inv,
  input  logic [0:NBYTES*8-1]   data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:NBYTES*8-1]   data_out,
  output logic                  busy
);

  localparam int GROUPS = NBYTES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int BW     = $clog2(NBYTES);
  localparam int LW     = $clog2(LANES);

  localparam logic [CW-1:0] LAST_GROUP = CW'(GROUPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Tables are packed with entry 0 at bit 0 (most significant), so entry x sits at [8x +: 8].
  localparam logic [0:2047] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]    state;
  logic [CW-1:0] grp;
  logic          inv_q;
  logic [7:0]    work_b [NBYTES];
  logic [BW-1:0] base;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
  logic          take;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_SUB) || (state == ST_DONE);
  assign take      = in_valid && in_ready;

  // First byte index of the group being substituted this cycle.
  assign base = BW'(grp) << LW;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l]  = work_b[base + BW'(l)];
    assign lane_out[l] = inv_q ? INV_TBL[{lane_in[l], 3'b000} +: 8]
                               : FWD_TBL[{lane_in[l], 3'b000} +: 8];
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_out
    assign data_out[8*k +: 8] = work_b[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      grp   <= '0;
      inv_q <= 1'b0;
      for (int k = 0; k < NBYTES; k++) begin
        work_b[k] <= '0;
      end
    end else if (take) begin
      // Covers both a fresh start from IDLE and a consume-and-restart from DONE.
      state <= ST_SUB;
      grp   <= '0;
      inv_q <= inv;
      for (int k = 0; k < NBYTES; k++) begin
        work_b[k] <= data_in[8*k +: 8];
      end
    end else begin
      case (state)
        ST_SUB: begin
          for (int l = 0; l < LANES; l++) begin
            work_b[base + BW'(l)] <= lane_out[l];
          end
          if (grp == LAST_GROUP) begin
            state <= ST_DONE;
          end else begin
            grp <= grp + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - bench for sub_bytes_engine: four configurations against a
// GF(2^8)-derived S-box model with cycle-level handshake expectations.
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv    [4];
  logic       ivn   [4];
  logic [0:127] din [4];
  logic       ordy  [4];
  logic       man   [4];
  logic       rnd   [4];
  logic       rand_mode [4];
  logic       ir    [4];
  logic       ov    [4];
  logic       bz    [4];
  logic [0:127] dout_w [4];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  // Configurations: (4,1) (4,2) (4,4) (16,4)
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NB = (g == 3) ? 16 : 4;
    localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [0:NB*8-1] di;
    logic [0:NB*8-1] dq;
    logic [0:127]    dw;
    assign di = din[g][0:NB*8-1];
    sub_bytes_engine #(.NBYTES(NB), .LANES(LN)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .inv(ivn[g]),
      .data_in(di), .out_valid(ov[g]), .out_ready(ordy[g]), .data_out(dq), .busy(bz[g])
    );
    always_comb begin
      dw = '0;
      dw[0:NB*8-1] = dq;
    end
    assign dout_w[g] = dw;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) ordy[i] = rand_mode[i] ? rnd[i] : man[i];
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) rnd[i] = 1'($urandom);
  end

  function automatic int nb_of(int i);
    return (i == 3) ? 16 : 4;
  endfunction

  function automatic int lat_of(int i);
    case (i)
      0: return 4;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [0:127] subst(int nb, logic mode, logic [0:127] w);
    logic [0:127] r = '0;
    for (int k = 0; k < nb; k++) r[8*k +: 8] = mode ? isb[w[8*k +: 8]] : sb[w[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(string name, logic [0:127] act, logic [0:127] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level model: accepted word appears after lat_of() edges and is held until consumed.
  int           cnt_m  [4];
  bit           vld_m  [4];
  bit           zero_m [4];
  logic [0:127] exp_m  [4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt_m[i] = 0; vld_m[i] = 0; zero_m[i] = 1; exp_m[i] = '0;
        chk("rst_out_valid", 128'(ov[i]), 128'(0));
        chk("rst_busy", 128'(bz[i]), 128'(0));
        chk("rst_data_out", dout_w[i], '0);
      end else begin
        logic rdy;
        rdy = (cnt_m[i] == 0) && (!vld_m[i] || ordy[i]);
        chk("in_ready", 128'(ir[i]), 128'(rdy));
        chk("out_valid", 128'(ov[i]), 128'(vld_m[i]));
        chk("busy", 128'(bz[i]), 128'((cnt_m[i] > 0) || vld_m[i]));
        if (vld_m[i]) chk("data_out", dout_w[i], exp_m[i]);
        else if (zero_m[i]) chk("data_out_idle_zero", dout_w[i], '0);
        if (vld_m[i] && ordy[i]) vld_m[i] = 0;
        if (cnt_m[i] > 0) begin
          cnt_m[i]--;
          if (cnt_m[i] == 0) vld_m[i] = 1;
        end else if (rdy && iv[i]) begin
          cnt_m[i]  = lat_of(i);
          exp_m[i]  = subst(nb_of(i), ivn[i], din[i]);
          zero_m[i] = 0;
        end
      end
    end
  end

  task automatic send(int i, logic m, logic [0:127] w);
    int t = 0;
    iv[i] = 1'b1; ivn[i] = m; din[i] = w;
    forever begin
      @(negedge clk);
      if (ir[i]) begin
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: inst %0d ready never seen", i);
        break;
      end
      @(posedge clk); #1;
    end
    iv[i] = 1'b0; ivn[i] = 1'($urandom); din[i] = {4{$urandom}};
  endtask

  task automatic wait_valid(int i, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (ov[i]) break;
      lat++;
      if (lat > 100) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic consume(int i);
    man[i] = 1'b1;
    @(posedge clk); #1;
    man[i] = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] gi;
    logic [7:0] s;
    logic [0:127] w;

    for (int a = 0; a < 256; a++) begin
      gi = '0;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) gi = 8'(b);
      s = gi ^ rotl(gi, 1) ^ rotl(gi, 2) ^ rotl(gi, 3) ^ rotl(gi, 4) ^ 8'h63;
      sb[a] = s;
      isb[s] = 8'(a);
    end
    chk("model_s00", 128'(sb[8'h00]), 128'(8'h63));
    chk("model_s53", 128'(sb[8'h53]), 128'(8'hed));
    chk("model_scf", 128'(sb[8'hcf]), 128'(8'h8a));
    chk("model_i63", 128'(isb[8'h63]), 128'(8'h00));

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 0; ivn[i] = 0; din[i] = '0; man[i] = 0; rand_mode[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 128'(ir[0]), 128'(1));
    @(posedge clk); #1;

    send(0, 1'b0, {32'hCF4F3C09, 96'h0});
    wait_valid(0, lat);
    chk("fwd_latency", 128'(lat), 128'(4));
    chk("fwd_vector", dout_w[0], {32'h8A84EB01, 96'h0});
    consume(0);

    send(0, 1'b1, {32'h8A84EB01, 96'h0});
    wait_valid(0, lat);
    chk("inv_vector", dout_w[0], {32'hCF4F3C09, 96'h0});
    consume(0);

    send(3, 1'b0, '0);
    wait_valid(3, lat);
    chk("w16_latency", 128'(lat), 128'(4));
    chk("w16_fwd_zero", dout_w[3], {16{8'h63}});
    consume(3);
    send(3, 1'b1, {16{8'h63}});
    wait_valid(3, lat);
    chk("w16_inv_63", dout_w[3], '0);
    consume(3);

    send(0, 1'b0, {32'h11111111, 96'h0});
    wait_valid(0, lat);
    for (int c = 0; c < 10; c++) begin
      iv[0] = 1'b1; ivn[0] = 1'($urandom); din[0] = {4{$urandom}};
      @(negedge clk);
      chk("hold_valid", 128'(ov[0]), 128'(1));
      chk("hold_data", dout_w[0], {32'h82828282, 96'h0});
      @(posedge clk); #1;
    end
    iv[0] = 1'b1; ivn[0] = 1'b0; din[0] = {32'h01234567, 96'h0}; man[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 128'(ir[0]), 128'(1));
    @(posedge clk); #1;
    iv[0] = 1'b0; man[0] = 1'b0; din[0] = {4{$urandom}};
    @(negedge clk);
    chk("b2b_no_bubble", 128'(bz[0]), 128'(1));
    @(posedge clk); #1;
    wait_valid(0, lat);
    chk("b2b_latency", 128'(lat), 128'(3));
    chk("b2b_vector", dout_w[0], {32'h7C266E85, 96'h0});
    consume(0);

    send(0, 1'b0, {32'h12345678, 96'h0});
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(ov[0]), 128'(0));
    chk("abort_busy", 128'(bz[0]), 128'(0));
    chk("abort_data_out", dout_w[0], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 1'b0, {32'h53535353, 96'h0});
    wait_valid(0, lat);
    chk("after_abort", dout_w[0], {32'hEDEDEDED, 96'h0});
    consume(0);

    for (int i = 0; i < 3; i++) begin
      rand_mode[i] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        for (int x = 0; x < 256; x += 4) begin
          w = '0;
          for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(x + b);
          send(i, 1'(m), w);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    end

    for (int i = 0; i < 4; i++) begin
      rand_mode[i] = 1'b1;
      for (int n = 0; n < 40; n++) begin
        send(i, 1'($urandom), {$urandom, $urandom, $urandom, $urandom});
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    end

    for (int i = 0; i < 4; i++) begin
      rand_mode[i] = 1'b0; man[i] = 1'b1;
    end
    repeat (10) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) chk("drained", 128'(bz[i]), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
